// File: rtl/fmap_stream_out.sv
// Feature-map serializer: captures one flattened map in a single cycle, then
// streams it one activation per beat tagged with (x, y, filter) coordinates.
module fmap_stream_out #(
    parameter int OUT_W       = 30,
    parameter int OUT_H       = 30,
    parameter int NUM_FILTERS = 16,
    parameter int ACTIV_BITS  = 8
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic [OUT_W*OUT_H*NUM_FILTERS*ACTIV_BITS-1:0]     fmap_data,
    input  logic                                              fmap_valid,
    output logic                                              fmap_ready,
    output logic [ACTIV_BITS-1:0]                             m_data,
    output logic [((OUT_W > 1) ? $clog2(OUT_W) : 1)-1:0]      m_x,
    output logic [((OUT_H > 1) ? $clog2(OUT_H) : 1)-1:0]      m_y,
    output logic [((NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1)-1:0] m_f,
    output logic                                              m_valid,
    input  logic                                              m_ready,
    output logic                                              m_last,
    output logic                                              overrun
);

    localparam int NUM_ELEMS = OUT_W * OUT_H * NUM_FILTERS;
    localparam int XW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int YW   = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int FW   = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
    localparam int IDXW = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;

    localparam logic [XW-1:0]   X_MAX    = XW'(OUT_W - 1);
    localparam logic [YW-1:0]   Y_MAX    = YW'(OUT_H - 1);
    localparam logic [FW-1:0]   F_MAX    = FW'(NUM_FILTERS - 1);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NUM_ELEMS - 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t                state_q;
    logic [ACTIV_BITS-1:0] fmap_elems [NUM_ELEMS];
    logic [ACTIV_BITS-1:0] frame_q    [NUM_ELEMS];

    logic [IDXW-1:0]       idx_q, idx_d;
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic [FW-1:0]         f_q, f_d;

    logic                  ready_q;
    logic                  valid_q;
    logic                  last_q;
    logic                  overrun_q;
    logic [ACTIV_BITS-1:0] data_q;

    logic                  capture;
    logic                  xfer;

    // Element i of the flattened bus is at bit offset i*ACTIV_BITS, which is
    // exactly the f-fastest / y / x streaming order.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_ELEMS; gi++) begin : g_unpack
            assign fmap_elems[gi] = fmap_data[gi*ACTIV_BITS +: ACTIV_BITS];
        end
    endgenerate

    assign capture = (state_q == S_IDLE) && fmap_valid;
    assign xfer    = (state_q == S_STREAM) && m_ready;

    always_ff @(posedge clk) begin
        if (capture) begin
            frame_q <= fmap_elems;
        end
    end

    always_comb begin
        idx_d = idx_q + 1'b1;
        x_d   = x_q;
        y_d   = y_q;
        f_d   = f_q + 1'b1;
        if (f_q == F_MAX) begin
            f_d = '0;
            y_d = y_q + 1'b1;
            if (y_q == Y_MAX) begin
                y_d = '0;
                x_d = (x_q == X_MAX) ? '0 : x_q + 1'b1;
            end
        end
    end

    // m_data is preloaded from the buffer one beat ahead so every output
    // comes straight from a register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            data_q    <= '0;
            idx_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            f_q       <= '0;
            overrun_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (fmap_valid) begin
                        state_q <= S_STREAM;
                        ready_q <= 1'b0;
                        valid_q <= 1'b1;
                        last_q  <= (NUM_ELEMS == 1);
                        data_q  <= fmap_elems[0];
                        idx_q   <= '0;
                        x_q     <= '0;
                        y_q     <= '0;
                        f_q     <= '0;
                    end
                end
                S_STREAM: begin
                    if (fmap_valid) begin
                        overrun_q <= 1'b1;
                    end
                    if (xfer) begin
                        if (last_q) begin
                            state_q <= S_IDLE;
                            ready_q <= 1'b1;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            data_q  <= '0;
                            idx_q   <= '0;
                            x_q     <= '0;
                            y_q     <= '0;
                            f_q     <= '0;
                        end else begin
                            last_q  <= (idx_d == IDX_LAST);
                            data_q  <= frame_q[idx_d];
                            idx_q   <= idx_d;
                            x_q     <= x_d;
                            y_q     <= y_d;
                            f_q     <= f_d;
                        end
                    end
                end
            endcase
        end
    end

    assign fmap_ready = ready_q;
    assign m_valid    = valid_q;
    assign m_last     = last_q;
    assign m_data     = data_q;
    assign m_x        = x_q;
    assign m_y        = y_q;
    assign m_f        = f_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_fmap_stream_out.sv
// Bench for fmap_stream_out on a 2x2x2 map: frame-level reference model
// checked every cycle, plus directed literal sequences.
module tb_fmap_stream_out;

    localparam int W  = 2;
    localparam int H  = 2;
    localparam int F  = 2;
    localparam int AB = 8;
    localparam int N  = W * H * F;
    localparam int BW = N * AB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [BW-1:0] fmap_data = '0;
    logic          fmap_valid = 1'b0;
    logic          m_ready = 1'b0;
    logic          fmap_ready;
    logic [AB-1:0] m_data;
    logic [0:0]    m_x, m_y, m_f;
    logic          m_valid, m_last, overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fmap_stream_out #(
        .OUT_W(W), .OUT_H(H), .NUM_FILTERS(F), .ACTIV_BITS(AB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .fmap_data(fmap_data), .fmap_valid(fmap_valid),
        .fmap_ready(fmap_ready), .m_data(m_data), .m_x(m_x), .m_y(m_y), .m_f(m_f),
        .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .overrun(overrun)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: whole frame held as a vector, progress as a beat index.
    bit            mdl_busy = 1'b0;
    bit            mdl_ovr = 1'b0;
    int            mdl_idx = 0;
    logic [BW-1:0] mdl_frame = '0;

    always @(posedge clk) begin
        if (rst_n !== 1'b1) begin
            mdl_busy = 1'b0;
            mdl_idx  = 0;
            mdl_ovr  = 1'b0;
        end else if (!mdl_busy) begin
            if (fmap_valid === 1'b1) begin
                mdl_frame = fmap_data;
                mdl_busy  = 1'b1;
                mdl_idx   = 0;
            end
        end else begin
            if (fmap_valid === 1'b1) mdl_ovr = 1'b1;
            if (m_ready === 1'b1) begin
                if (mdl_idx == N - 1) begin
                    mdl_busy = 1'b0;
                    mdl_idx  = 0;
                end else begin
                    mdl_idx++;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("fmap_ready", 64'(fmap_ready), 64'(!mdl_busy));
        check("m_valid", 64'(m_valid), 64'(mdl_busy));
        check("m_last", 64'(m_last), 64'(mdl_busy && mdl_idx == N - 1));
        check("overrun", 64'(overrun), 64'(mdl_ovr));
        if (mdl_busy) begin
            check("m_data", 64'(m_data), 64'(mdl_frame[mdl_idx*AB +: AB]));
            check("m_f", 64'(m_f), 64'(mdl_idx % F));
            check("m_y", 64'(m_y), 64'((mdl_idx / F) % H));
            check("m_x", 64'(m_x), 64'(mdl_idx / (F * H)));
        end else begin
            check("m_xyf_idle", 64'({m_x, m_y, m_f}), 64'(0));
        end
    end

    typedef struct {
        logic [AB-1:0] d;
        int            x;
        int            y;
        int            f;
        logic          last;
    } beat_t;

    beat_t log_q[$];

    always @(negedge clk) begin
        if (rst_n === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
            log_q.push_back('{m_data, int'(m_x), int'(m_y), int'(m_f), m_last});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame(input logic [BW-1:0] d);
        fmap_data  = d;
        fmap_valid = 1'b1;
        tick();
        fmap_valid = 1'b0;
    endtask

    task automatic wait_beats(input string name, input bit toggle);
        logic [3:0] pat;
        pat = 4'b1001;
        for (int c = 0; c < 200 && log_q.size() < N; c++) begin
            if (toggle) m_ready = pat[c % 4];
            tick();
        end
        m_ready = 1'b1;
        check({name, "_beat_count"}, 64'(log_q.size()), 64'(N));
    endtask

    task automatic check_log(input string name, input logic [AB-1:0] first, input int step);
        logic [AB-1:0] exp_d;
        for (int i = 0; i < N && i < log_q.size(); i++) begin
            exp_d = first + AB'(step * i);
            check({name, "_data"}, 64'(log_q[i].d), 64'(exp_d));
            check({name, "_xyf"}, 64'({log_q[i].x[1:0], log_q[i].y[1:0], log_q[i].f[1:0]}),
                  64'({2'(i >> 2), 2'((i >> 1) & 1), 2'(i & 1)}));
            check({name, "_last"}, 64'(log_q[i].last), 64'(i == N - 1));
        end
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 40 && fmap_ready !== 1'b1; c++) tick();
        check("wait_idle", 64'(fmap_ready), 64'(1));
        tick();
    endtask

    initial begin
        // Reset then idle
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_fmap_ready", 64'(fmap_ready), 64'(1));
        check("rst_m_valid", 64'(m_valid), 64'(0));
        check("rst_overrun", 64'(overrun), 64'(0));
        check("rst_m_last", 64'(m_last), 64'(0));
        check("rst_m_data", 64'(m_data), 64'(0));
        check("rst_xyf", 64'({m_x, m_y, m_f}), 64'(0));

        // Basic frame
        m_ready = 1'b1;
        log_q.delete();
        pulse_frame(64'h0807060504030201);
        check("basic_first", 64'({m_valid, fmap_ready, m_data}), 64'({1'b1, 1'b0, 8'h01}));
        wait_beats("basic", 1'b0);
        check_log("basic", 8'h01, 1);
        check("basic_ready_after", 64'(fmap_ready), 64'(1));
        tick();

        // Backpressure
        log_q.delete();
        pulse_frame(64'h0807060504030201);
        wait_beats("bp", 1'b1);
        check_log("bp", 8'h01, 1);
        wait_idle();

        // Overrun during 3rd beat
        log_q.delete();
        pulse_frame(64'h0807060504030201);
        tick();
        tick();
        check("ovr_beat3", 64'(m_data), 64'(8'h03));
        fmap_data  = '1;
        fmap_valid = 1'b1;
        tick();
        fmap_valid = 1'b0;
        check("ovr_set", 64'(overrun), 64'(1));
        wait_beats("ovr", 1'b0);
        check_log("ovr", 8'h01, 1);
        check("ovr_sticky", 64'(overrun), 64'(1));
        wait_idle();

        // Reset mid-frame at beat 4
        pulse_frame(64'h0807060504030201);
        tick();
        tick();
        tick();
        check("mid_beat4", 64'(m_data), 64'(8'h04));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_valid", 64'(m_valid), 64'(0));
        check("mid_rst_overrun", 64'(overrun), 64'(0));
        log_q.delete();
        pulse_frame(64'h1122334455667788);
        wait_beats("mid", 1'b0);
        check_log("mid", 8'h88, -8'sh11);
        wait_idle();

        // Back-to-back with fmap_valid held high
        fmap_data  = 64'h0807060504030201;
        fmap_valid = 1'b1;
        tick();
        for (int i = 0; i < 18; i++) begin
            check("b2b_valid", 64'(m_valid), 64'(i != 8 && i != 17));
            tick();
        end
        fmap_valid = 1'b0;
        wait_idle();

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            m_ready    = ($urandom_range(0, 3) != 0);
            fmap_valid = ($urandom_range(0, 7) == 0);
            fmap_data  = {$urandom, $urandom};
            rst_n      = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst_n      = 1'b1;
        fmap_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
